// File: rtl/seg_mux_capture.sv
// Receive side of a scanned 4-digit 7-segment display: synchronizes the anode and
// segment lines, captures each stable glyph once and rebuilds the 4-digit hex value.
module seg_mux_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [3:0]  i_Anodo,
  input  logic [6:0]  i_Seg,
  output logic [15:0] o_Digits,
  output logic [3:0]  o_Valid_Digit,
  output logic        o_Frame,
  output logic        o_Err
);

  typedef enum logic {S_SETTLE, S_HOLD} state_t;

  localparam logic [2:0] CNT_MAX     = 3'(STABLE_CYCLES);
  localparam logic [2:0] CNT_CAPTURE = 3'(STABLE_CYCLES - 1);

  logic [10:0] sync1, sync2;
  logic [2:0]  cnt;
  logic [3:0]  seen;
  state_t      state, state_next;

  logic        changed, capture;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [3:0]  nibble;
  logic        glyph_ok, one_hot, multi_hot, frame_done;

  assign anode      = sync2[10:7];
  assign seg        = sync2[6:0];
  // sync1 is exactly what sync2 loads on the next edge, so this flags a change before it lands
  assign changed    = (sync1 != sync2);
  assign multi_hot  = ((anode & (anode - 4'd1)) != 4'd0);
  assign one_hot    = (anode != 4'd0) && !multi_hot;
  assign frame_done = one_hot && ((seen | anode) == 4'hF);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_SETTLE: begin
        if (!changed && cnt == CNT_CAPTURE) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (changed) state_next = S_SETTLE;
      end
      default: state_next = S_SETTLE;
    endcase
  end

  always_comb begin
    glyph_ok = 1'b1;
    nibble   = 4'h0;
    case (seg)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: begin
        glyph_ok = 1'b0;
        nibble   = 4'h0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1         <= '0;
      sync2         <= '0;
      cnt           <= '0;
      seen          <= '0;
      state         <= S_SETTLE;
      o_Digits      <= '0;
      o_Valid_Digit <= '0;
      o_Frame       <= 1'b0;
      o_Err         <= 1'b0;
    end else begin
      sync1   <= {i_Anodo, i_Seg};
      sync2   <= sync1;
      state   <= state_next;
      o_Frame <= capture && frame_done;
      o_Err   <= capture && multi_hot;

      if (changed)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 3'd1;

      if (capture && one_hot) begin
        for (int k = 0; k < 4; k++) begin
          if (anode[k]) begin
            o_Digits[4*k +: 4] <= nibble;
            o_Valid_Digit[k]   <= glyph_ok;
          end
        end
        // Completing the frame restarts tracking on the same edge as the pulse
        seen <= frame_done ? 4'h0 : (seen | anode);
      end
    end
  end

endmodule

// File: tb/tb_seg_mux_capture.sv
// Scoreboard bench for seg_mux_capture: a reference model predicts each visible capture
// and a negedge monitor matches what the DUT presents against the queue.
module tb_seg_mux_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  val;
    logic        frame;
    logic        err;
  } exp_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic [3:0]  i_Anodo = 4'h0;
  logic [6:0]  i_Seg = 7'h00;
  logic [15:0] o_Digits;
  logic [3:0]  o_Valid_Digit;
  logic        o_Frame;
  logic        o_Err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  exp_t exp_q[$];

  logic [3:0]  m_dig [4];
  logic        m_val [4];
  logic        m_seen [4];
  logic [10:0] cur_pat = '0;
  logic [15:0] prev_d = '0;
  logic [3:0]  prev_v = '0;

  seg_mux_capture #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Anodo(i_Anodo), .i_Seg(i_Seg),
    .o_Digits(o_Digits), .o_Valid_Digit(o_Valid_Digit), .o_Frame(o_Frame), .o_Err(o_Err)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [15:0] modelDigits();
    logic [15:0] d = '0;
    for (int k = 0; k < 4; k++) d[4*k +: 4] = m_dig[k];
    return d;
  endfunction

  function automatic logic [3:0] modelValid();
    logic [3:0] v = '0;
    for (int k = 0; k < 4; k++) v[k] = m_val[k];
    return v;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 4; k++) begin
      m_dig[k] = 4'h0;
      m_val[k] = 1'b0;
      m_seen[k] = 1'b0;
    end
  endtask

  // What a single accepted glyph does to the display image, queued only if it is visible
  task automatic modelCapture(input logic [3:0] an, input logic [6:0] sg, input int c);
    exp_t e;
    int k;
    logic [3:0] nib;
    logic legal, diff, frame;
    if (an == 4'h0) return;
    if ($countones(an) > 1) begin
      e = '{c, modelDigits(), modelValid(), 1'b0, 1'b1};
      exp_q.push_back(e);
      return;
    end
    k = 0;
    for (int b = 0; b < 4; b++) if (an[b]) k = b;
    legal = 1'b0;
    nib = 4'h0;
    for (int g = 0; g < 16; g++) begin
      if (GLYPH[g] == sg) begin
        legal = 1'b1;
        nib = 4'(g);
      end
    end
    diff = (m_dig[k] != nib) || (m_val[k] != legal);
    m_dig[k] = nib;
    m_val[k] = legal;
    m_seen[k] = 1'b1;
    frame = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
    if (frame) for (int j = 0; j < 4; j++) m_seen[j] = 1'b0;
    if (frame || diff) begin
      e = '{c, modelDigits(), modelValid(), frame, 1'b0};
      exp_q.push_back(e);
    end
  endtask

  // A pattern survives the filter once it has been on the pins for STABLE+1 cycles
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] sg, input int hold);
    i_Anodo = an;
    i_Seg = sg;
    cur_pat = {an, sg};
    if (hold >= STABLE + 1) modelCapture(an, sg, cyc + STABLE + 2);
    repeat (hold) @(negedge i_Clk);
  endtask

  task automatic resetPulse();
    i_Anodo = 4'h0;
    i_Seg = 7'h00;
    #2 i_Rst = 1'b1;
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc > cyc) exp_q.delete(i);
    modelClear();
    #1 checkOutput("async_reset", {43'd0, o_Digits, o_Valid_Digit, o_Frame, o_Err}, 64'd0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    cur_pat = '0;
  endtask

  always @(negedge i_Clk) begin
    exp_t e;
    if (i_Rst) begin
      prev_d = '0;
      prev_v = '0;
    end else begin
      if (o_Digits != prev_d || o_Valid_Digit != prev_v || o_Frame || o_Err) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_event at cycle %0d: got dig=%h val=%b frame=%b err=%b, expected none",
                   cyc, o_Digits, o_Valid_Digit, o_Frame, o_Err);
        end else begin
          e = exp_q.pop_front();
          checkOutput("capture", {10'd0, 32'(cyc), o_Digits, o_Valid_Digit, o_Frame, o_Err},
                      {10'd0, 32'(e.cyc), e.dig, e.val, e.frame, e.err});
        end
      end
      prev_d = o_Digits;
      prev_v = o_Valid_Digit;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] an;
    logic [6:0] sg;
    int hold;
    modelClear();
    #1 checkOutput("reset_state", {43'd0, o_Digits, o_Valid_Digit, o_Frame, o_Err}, 64'd0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;

    applyStimulus(4'b0001, 7'h06, 20);
    applyStimulus(4'b0001, 7'h06, 0);
    applyStimulus(4'b0000, 7'h00, 8);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(4'b0001, 7'h06, 8);
      applyStimulus(4'b0010, 7'h5B, 8);
      applyStimulus(4'b0100, 7'h4F, 8);
      applyStimulus(4'b1000, 7'h66, 8);
    end
    applyStimulus(4'b0010, 7'h7F, 3);
    applyStimulus(4'b0010, 7'h39, 8);
    applyStimulus(4'b0011, 7'h39, 10);
    applyStimulus(4'b0100, 7'h00, 10);
    applyStimulus(4'b0000, 7'h00, 8);

    resetPulse();
    applyStimulus(4'b0001, 7'h3F, 8);
    applyStimulus(4'b0010, 7'h06, 8);
    resetPulse();
    applyStimulus(4'b0100, 7'h5B, 8);
    applyStimulus(4'b1000, 7'h4F, 8);
    applyStimulus(4'b0001, 7'h66, 8);
    applyStimulus(4'b0010, 7'h6D, 8);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) resetPulse();
      do begin
        case ($urandom_range(0, 9))
          0: an = 4'h0;
          1: begin
            do an = 4'($urandom); while ($countones(an) < 2);
          end
          default: an = 4'b0001 << $urandom_range(0, 3);
        endcase
        sg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : GLYPH[$urandom_range(0, 15)];
      end while ({an, sg} == cur_pat);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : $urandom_range(5, 14);
      applyStimulus(an, sg, hold);
    end

    if (cur_pat == 11'h001) applyStimulus(4'h0, 7'h02, 10);
    else applyStimulus(4'h0, 7'h01, 10);
    repeat (12) @(negedge i_Clk);
    checkOutput("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_mux_capture.md
# seg_mux_capture

Receive-side counterpart of the multiplexed 7-segment display driver. It samples the one-hot anode strobes and segment lines of a 4-digit scanned display and filters out switching glitches. Each stable glyph is decoded back to a hex nibble, and the block reconstructs the 4-digit value, flagging each completed frame. It is used for display loopback checking and for board-level self-test.

## Interface
- STABLE_CYCLES, 4: consecutive unchanged synchronized samples required before a capture (legal range 2..7).
- i_Clk  in  1  capture clock; may be asynchronous to the display driver.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Anodo  in  4  anode strobes, active-high, one-hot; bit k selects digit k.
- i_Seg  in  7  segments, active-high; bit0=a … bit6=g.
- o_Digits  out  16  reconstructed digits; digit k at [4k+3:4k].
- o_Valid_Digit  out  4  bit k=1: last capture of digit k was a legal hex glyph.
- o_Frame  out  1  one-cycle pulse when all 4 digits have been captured since the previous frame or reset.
- o_Err  out  1  one-cycle pulse on a stable multi-hot anode pattern.

## Operation
- Two-flop synchronizer on {i_Anodo, i_Seg} (11 bits). Only the second stage (sync2) feeds the logic.
- Stability counter cnt (3 bits):
  - Cleared to 0 on any edge where sync2 loads a value different from its previous value.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - S_SETTLE (reset state): counting. When the pattern is unchanged and cnt == STABLE_CYCLES-1, perform a capture and go to S_HOLD.
  - S_HOLD: no further captures. Any change in sync2 returns the FSM to S_SETTLE with cnt=0.
- Capture action, by anode pattern:
  - Anode == 0000 (blanking): no write, no error.
  - Anode one-hot (digit k): decode the glyph into digit k, set seen[k].
  - Anode multi-hot: o_Err=1 for one cycle; no digit, valid or seen update.
- Glyph decode (hex segment value → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - A listed glyph sets o_Valid_Digit[k]=1.
  - Any other segment value writes nibble 0 and sets o_Valid_Digit[k]=0. seen[k] is still set.
- Frame completion: when a capture makes seen == 1111:
  - o_Frame=1 for one cycle.
  - seen clears to 0000 in the same edge.
- Recapturing an already-seen digit overwrites its nibble and valid bit. seen is unchanged.
- Reset (asynchronous, at any time) clears:
  - sync stages, cnt, seen;
  - FSM to S_SETTLE;
  - o_Digits=0, o_Valid_Digit=0, o_Frame=0, o_Err=0.
  - Reset asserted mid-frame discards partial progress.

## Timing
- Input pattern settled before edge 1:
  - sync1 loads at edge 1, sync2 at edge 2 (cnt=0).
  - cnt reaches STABLE_CYCLES-1 at edge STABLE_CYCLES+1.
  - Capture registers at edge STABLE_CYCLES+2 (edge 6 for the default).
- o_Digits, o_Valid_Digit, o_Frame and o_Err are all registered and update on the capture edge. o_Frame and o_Err deassert on the next edge.
- A pattern whose sync2 value stays unchanged for fewer than STABLE_CYCLES+1 sync2 samples (at most STABLE_CYCLES edges) is ignored.
- Throughput: at most one capture per stable pattern. A pattern held indefinitely yields exactly one capture.
- Anode and segment lines changing on different cycles appear as separate patterns. The transient combination is rejected by the stability filter when it lasts fewer than STABLE_CYCLES+1 sync2 samples.

## Test plan
- Reset: assert i_Rst mid-run → o_Digits=0000, o_Valid_Digit=0000, o_Frame=0, o_Err=0 immediately, without waiting for a clock.
- Single digit: i_Anodo=0001, i_Seg=06 held 20 cycles → o_Digits[3:0]=1 and o_Valid_Digit[0]=1 at edge 6; exactly one capture; no o_Frame.
- Full frame: digits 0..3 show glyphs 06, 5B, 4F, 66, each held 8 cycles → o_Digits=4321 hex, o_Valid_Digit=1111, a single o_Frame pulse after the digit-3 capture; repeat the sequence → second o_Frame pulse.
- Glitch rejection: i_Anodo=0010, i_Seg=7F held 3 cycles, then 0010/39 held 8 cycles → o_Digits[7:4]=C, never 8.
- Errors: i_Anodo=0011 held 10 cycles → exactly one o_Err pulse, outputs unchanged; i_Anodo=0100, i_Seg=00 held 10 cycles → o_Digits[11:8]=0, o_Valid_Digit[2]=0, seen[2] set.
- Reset mid-frame: capture digits 0 and 1, pulse i_Rst, capture digits 2 and 3 → no o_Frame; then capture digits 0 and 1 → o_Frame pulses once.
